exe_issue_ctrl: RTL and testbench
=================================

Name: exe_issue_ctrl

Overview:
Issue controller between Decode and the Execute stage. It holds a register scoreboard and a multi-cycle busy state machine. It decides each cycle whether the decoded instruction may enter Execute, or whether Decode must stall. It also tracks outstanding register writes until writeback and handles pipeline flush.

Parameters:
NREGS, 32, number of architectural registers; register 0 is hardwired zero.
REG_W, 5, register index width (log2 NREGS).
LAT_W, 4, width of the multi-cycle latency field; maximum latency is 2^LAT_W-1.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
dec_valid  in  1  Decode presents an instruction
dec_rs1  in  REG_W  source register 1
dec_rs2  in  REG_W  source register 2
dec_rd  in  REG_W  destination register
dec_rd_wen  in  1  instruction writes rd
dec_multi  in  1  instruction occupies Execute for multiple cycles
dec_lat  in  LAT_W  extra busy cycles for a multi-cycle op; ignored when dec_multi=0
wb_valid  in  1  writeback retires a register write
wb_rd  in  REG_W  register being written back
flush  in  1  kill all in-flight and presented work
dec_stall  out  1  Decode must hold its current instruction
exe_issue  out  1  instruction enters Execute this cycle (valid to Execute)
exe_busy  out  1  Execute is occupied by a multi-cycle op
pending  out  NREGS  scoreboard bits, for debug and trace

Behaviour:
- State: pending[NREGS-1:0], FSM {IDLE, BUSY}, down-counter cnt[LAT_W-1:0].
- Reset (rst=0 at a clk edge): pending=0, FSM=IDLE, cnt=0. Outputs: exe_issue=0, dec_stall=0, exe_busy=0.
- Hazard check uses registered pending only; there is no same-cycle bypass from wb:
  - raw = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2])
  - waw = dec_rd_wen && rd!=0 && pending[rd]
- exe_issue = dec_valid && !raw && !waw && FSM==IDLE && !flush. This is combinational from registered state and inputs.
- dec_stall = dec_valid && !exe_issue && !flush.
- exe_busy = (FSM==BUSY).
- Scoreboard update at each clk edge:
  - Set: if exe_issue && dec_rd_wen && rd!=0, set pending[rd].
  - Clear: if wb_valid && wb_rd!=0, clear pending[wb_rd].
  - Set and clear never hit the same index in one cycle, because waw blocks issue to a pending rd.
  - A wb to a non-pending register has no effect.
  - pending[0] is always 0.
- FSM transitions:
  - IDLE: exe_issue && dec_multi && dec_lat!=0 -> BUSY, cnt=dec_lat.
  - IDLE: dec_multi with dec_lat==0 behaves as single-cycle and stays IDLE.
  - BUSY: cnt decrements by 1 per cycle. When cnt==1, go to IDLE at that edge, so the next instruction can issue in the cycle after.
  - A multi-cycle op issued in cycle T therefore blocks issue for cycles T+1 .. T+dec_lat.
- flush: at the edge, pending=0, FSM=IDLE, cnt=0. In the same cycle exe_issue=0 and dec_stall=0. A wb_valid in the flush cycle is ignored. flush has priority over every other update.
- rst during BUSY returns to reset state immediately; no partial countdown survives.

Decomposition:
- Shared pipeline package holds:
  - register index typedef (REG_W bits);
  - latency typedef (LAT_W bits);
  - FSM state enum {IDLE, BUSY};
  - constant ZERO_REG = 0.
- One natural sub-module: exe_scoreboard. It contains the pending vector with set, clear, flush and two read ports plus one write-check port. The FSM, counter and issue logic stay in exe_issue_ctrl.

Test Plan:
1. Reset, then dec_valid with rs1=1, rs2=2, rd=3 and wen=1 -> exe_issue=1 in the same cycle; pending[3]=1 on the next cycle.
2. RAW: issue rd=5, then present rs1=5 -> dec_stall=1 until wb_valid with wb_rd=5. Issue happens in the cycle after the wb edge (no bypass).
3. Multi-cycle: issue with dec_multi=1, dec_lat=3 at cycle T -> exe_busy=1 in T+1..T+3 and stall for independent instructions then; issue at T+4.
4. Register 0: rd=0 with wen=1 issues and pending stays 0; rs1=0 never stalls.
5. WAW: pending[7]=1, present rd=7 -> stall. The wb of 7 and the issue of rd=7 in the following cycle leave pending[7]=1.
6. Flush during BUSY, with cnt=2 and pending[4]=1 -> next cycle FSM=IDLE, pending=0, and the waiting instruction issues. A concurrent wb in the flush cycle is ignored.

Source files
------------

// File: rtl/exe_issue_ctrl_pkg.sv
// Shared pipeline definitions for the Decode -> Execute issue slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: register index / latency types, issue FSM state encoding, zero-register constant.
package exe_issue_ctrl_pkg;

    localparam int NREGS_DEF = 32;
    localparam int REG_W_DEF = 5;
    localparam int LAT_W_DEF = 4;

    typedef logic [REG_W_DEF-1:0] reg_idx_t;
    typedef logic [LAT_W_DEF-1:0] lat_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } issue_state_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/exe_scoreboard.sv
// Register scoreboard: one pending bit per architectural register, set on issue, cleared on writeback.
// Latency: reads are combinational from the registered vector; updates land at the next clk edge.
// Backpressure: none; hits are consumed by the issue logic, which is what stalls Decode.
// Ports: clk/rst (sync, active-low); set_en/set_idx, clr_en/clr_idx, flush update the vector;
//        rd1_idx/rd2_idx -> rd1_hit/rd2_hit (source checks), chk_idx -> chk_hit (destination check);
//        pending exposes the whole vector for debug and trace.
module exe_scoreboard
    import exe_issue_ctrl_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic [REG_W-1:0] rd1_idx,
    input  logic [REG_W-1:0] rd2_idx,
    input  logic [REG_W-1:0] chk_idx,
    output logic             rd1_hit,
    output logic             rd2_hit,
    output logic             chk_hit,
    output logic [NREGS-1:0] pending
);

    logic [NREGS-1:0] pending_nxt;

    // Register 0 never reports a hit, regardless of what the vector holds.
    assign rd1_hit = (rd1_idx != REG_W'(ZERO_REG)) && pending[rd1_idx];
    assign rd2_hit = (rd2_idx != REG_W'(ZERO_REG)) && pending[rd2_idx];
    assign chk_hit = (chk_idx != REG_W'(ZERO_REG)) && pending[chk_idx];

    // Set and clear never collide on one index: a pending rd blocks issue.
    // Clearing a bit that is already 0 is harmless, which covers stray writebacks.
    always_comb begin
        pending_nxt = pending;
        if (set_en) begin
            pending_nxt[set_idx] = 1'b1;
        end
        if (clr_en) begin
            pending_nxt[clr_idx] = 1'b0;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/exe_issue_ctrl.sv
// Issue controller between Decode and Execute: RAW/WAW hazard check, multi-cycle busy FSM, flush.
// Latency: exe_issue is combinational in the presented cycle; scoreboard/FSM update at the next edge.
// Backpressure: dec_stall holds Decode while a hazard or a busy Execute blocks the presented op.
// Ports: clk/rst (sync, active-low); dec_* describe the presented instruction; wb_valid/wb_rd retire
//        a register write; flush kills in-flight work; outputs dec_stall, exe_issue, exe_busy, pending.
module exe_issue_ctrl
    import exe_issue_ctrl_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_rd_wen,
    input  logic             dec_multi,
    input  logic [LAT_W-1:0] dec_lat,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             flush,
    output logic             dec_stall,
    output logic             exe_issue,
    output logic             exe_busy,
    output logic [NREGS-1:0] pending
);

    issue_state_t     state;
    logic [LAT_W-1:0] cnt;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             rd_hit;
    logic             raw;
    logic             waw;
    logic             sb_set;
    logic             sb_clr;

    assign raw = rs1_hit || rs2_hit;
    assign waw = dec_rd_wen && rd_hit;

    // Hazards are judged against registered pending only; a writeback in the
    // same cycle does not release a stalled consumer until the following cycle.
    assign exe_issue = dec_valid && !raw && !waw && (state == IDLE) && !flush;
    assign dec_stall = dec_valid && !exe_issue && !flush;
    assign exe_busy  = (state == BUSY);

    assign sb_set = exe_issue && dec_rd_wen;
    assign sb_clr = wb_valid;

    exe_scoreboard #(
        .NREGS (NREGS),
        .REG_W (REG_W)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .set_en  (sb_set),
        .set_idx (dec_rd),
        .clr_en  (sb_clr),
        .clr_idx (wb_rd),
        .rd1_idx (dec_rs1),
        .rd2_idx (dec_rs2),
        .chk_idx (dec_rd),
        .rd1_hit (rs1_hit),
        .rd2_hit (rs2_hit),
        .chk_hit (rd_hit),
        .pending (pending)
    );

    // A multi-cycle op issued at cycle T holds Execute for T+1 .. T+dec_lat:
    // cnt is loaded with dec_lat and the FSM leaves BUSY at the edge where cnt==1.
    // A zero latency is treated as a single-cycle op and never enters BUSY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (exe_issue && dec_multi && (dec_lat != '0)) begin
                        state <= BUSY;
                        cnt   <= dec_lat;
                    end
                end
                BUSY: begin
                    // cnt==0 cannot occur in BUSY; treat it as done rather than wrap.
                    if (cnt <= LAT_W'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - LAT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Directed bench for exe_issue_ctrl: hazards, multi-cycle busy, register 0, flush and reset.
// Latency: inputs change 1 time unit after each rising edge; outputs are sampled 3 units later.
// Backpressure: dec_stall is checked against hand-computed expectations at every step.
module tb_exe_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_rd_wen;
    logic        dec_multi;
    logic [3:0]  dec_lat;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        dec_stall;
    logic        exe_issue;
    logic        exe_busy;
    logic [31:0] pending;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_issue_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .dec_valid  (dec_valid),
        .dec_rs1    (dec_rs1),
        .dec_rs2    (dec_rs2),
        .dec_rd     (dec_rd),
        .dec_rd_wen (dec_rd_wen),
        .dec_multi  (dec_multi),
        .dec_lat    (dec_lat),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .flush      (flush),
        .dec_stall  (dec_stall),
        .exe_issue  (exe_issue),
        .exe_busy   (exe_busy),
        .pending    (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the three control outputs in one go.
    task automatic chk_ctl(input string tag, input logic iss, input logic stl, input logic bsy);
        chk({tag, ".issue"}, {31'd0, exe_issue}, {31'd0, iss});
        chk({tag, ".stall"}, {31'd0, dec_stall}, {31'd0, stl});
        chk({tag, ".busy"},  {31'd0, exe_busy},  {31'd0, bsy});
    endtask

    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic wen, input logic multi, input logic [3:0] lat);
        dec_valid  = 1'b1;
        dec_rs1    = rs1;
        dec_rs2    = rs2;
        dec_rd     = rd;
        dec_rd_wen = wen;
        dec_multi  = multi;
        dec_lat    = lat;
    endtask

    task automatic quiet();
        dec_valid  = 1'b0;
        dec_rs1    = '0;
        dec_rs2    = '0;
        dec_rd     = '0;
        dec_rd_wen = 1'b0;
        dec_multi  = 1'b0;
        dec_lat    = '0;
        wb_valid   = 1'b0;
        wb_rd      = '0;
        flush      = 1'b0;
    endtask

    // Advance one clock; inputs may change right after, outputs settle by +3.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        quiet();
        rst = 1'b0;
        step();
        step();
        settle();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.pending", pending, 32'h0);

        // 1: independent instruction issues at once; rd=3 pending next cycle.
        rst = 1'b1;
        present(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 4'd0);
        settle();
        chk_ctl("t1.first", 1'b1, 1'b0, 1'b0);
        step();
        quiet();
        settle();
        chk("t1.pending3", pending, 32'h0000_0008);

        // 2: RAW on r5, released only the cycle after the writeback edge.
        present(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 4'd0);
        settle();
        chk_ctl("t2.prod", 1'b1, 1'b0, 1'b0);
        step();
        present(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 4'd0);
        settle();
        chk_ctl("t2.raw0", 1'b0, 1'b1, 1'b0);
        chk("t2.pending35", pending, 32'h0000_0028);
        step();
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        settle();
        chk_ctl("t2.raw_wb", 1'b0, 1'b1, 1'b0);
        step();
        wb_valid = 1'b0;
        settle();
        chk_ctl("t2.release", 1'b1, 1'b0, 1'b0);
        chk("t2.pend_after_wb", pending, 32'h0000_0008);
        step();
        quiet();
        settle();
        chk("t2.pending36", pending, 32'h0000_0048);

        // 3: multi-cycle op with latency 3 blocks T+1..T+3.
        present(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 4'd3);
        settle();
        chk_ctl("t3.T", 1'b1, 1'b0, 1'b0);
        step();
        present(5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 4'd0);
        settle();
        chk_ctl("t3.T1", 1'b0, 1'b1, 1'b1);
        step();
        settle();
        chk_ctl("t3.T2", 1'b0, 1'b1, 1'b1);
        step();
        settle();
        chk_ctl("t3.T3", 1'b0, 1'b1, 1'b1);
        step();
        settle();
        chk_ctl("t3.T4", 1'b1, 1'b0, 1'b0);
        step();
        quiet();
        settle();
        chk("t3.pending368", pending, 32'h0000_0148);

        // Multi with zero latency acts as single-cycle.
        present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'd0);
        settle();
        chk_ctl("lat0.issue", 1'b1, 1'b0, 1'b0);
        step();
        quiet();
        settle();
        chk("lat0.nobusy", {31'd0, exe_busy}, 32'd0);

        // 4: register 0 as destination and as source never creates a hazard.
        present(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 4'd0);
        settle();
        chk_ctl("t4.rd0", 1'b1, 1'b0, 1'b0);
        step();
        present(5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 4'd0);
        settle();
        chk("t4.pend0", pending, 32'h0000_0148);
        chk_ctl("t4.rs0", 1'b1, 1'b0, 1'b0);
        step();
        // Writeback to a non-pending register and to r0, plus r10 retire.
        quiet();
        wb_valid = 1'b1;
        wb_rd    = 5'd9;
        step();
        wb_rd = 5'd0;
        step();
        wb_rd = 5'd10;
        step();
        quiet();
        settle();
        chk("t4.wb_nonpending", pending, 32'h0000_0148);

        // 5: WAW on r7; wb and re-issue leave r7 pending.
        present(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 4'd0);
        settle();
        chk_ctl("t5.set7", 1'b1, 1'b0, 1'b0);
        step();
        present(5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 4'd0);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        settle();
        chk_ctl("t5.waw", 1'b0, 1'b1, 1'b0);
        chk("t5.pend_waw", pending, 32'h0000_01C8);
        step();
        wb_valid = 1'b0;
        settle();
        chk_ctl("t5.reissue", 1'b1, 1'b0, 1'b0);
        chk("t5.pend_cleared", pending, 32'h0000_0148);
        step();
        // Same rd without a write enable is not a WAW hazard.
        present(5'd1, 5'd0, 5'd7, 1'b0, 1'b0, 4'd0);
        settle();
        chk("t5.pend_reset7", pending, 32'h0000_01C8);
        chk_ctl("t5.nowen", 1'b1, 1'b0, 1'b0);
        step();

        // 6: flush while BUSY with cnt=2 and r4 pending; concurrent wb ignored.
        present(5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 4'd3);
        settle();
        chk_ctl("t6.T", 1'b1, 1'b0, 1'b0);
        step();
        present(5'd4, 5'd0, 5'd9, 1'b1, 1'b0, 4'd0);
        settle();
        chk_ctl("t6.T1", 1'b0, 1'b1, 1'b1);
        chk("t6.pend4", pending, 32'h0000_01D8);
        step();
        flush    = 1'b1;
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        settle();
        chk_ctl("t6.flush", 1'b0, 1'b0, 1'b1);
        step();
        flush    = 1'b0;
        wb_valid = 1'b0;
        settle();
        chk_ctl("t6.after", 1'b1, 1'b0, 1'b0);
        chk("t6.pend_clear", pending, 32'h0000_0000);
        step();
        quiet();
        settle();
        chk("t6.pend9", pending, 32'h0000_0200);

        // Reset in the middle of a long multi-cycle op.
        present(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 4'd5);
        settle();
        chk_ctl("rstbusy.issue", 1'b1, 1'b0, 1'b0);
        step();
        quiet();
        settle();
        chk("rstbusy.busy", {31'd0, exe_busy}, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        present(5'd9, 5'd0, 5'd2, 1'b1, 1'b0, 4'd0);
        settle();
        chk_ctl("rstbusy.after", 1'b1, 1'b0, 1'b0);
        chk("rstbusy.pending", pending, 32'h0000_0000);
        step();
        quiet();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
